matrix_op_sequencer: RTL and testbench
======================================

// Module: matrix_op_sequencer
// PURPOSE
//  Drives the matrix ALU datapath element by element. Reads operand A and operand B
//  from the dual-port matrix RAM: port A for operand A, port B for operand B.
//  Presents both operands and the op code to the external combinational ALU.
//  Writes the ALU result back through port A.
//  Sits between the top-level FSM (start/done handshake) and the RAM + ALU.
// PARAMETERS
//  DATA_W  16  width of matrix elements / RAM words / ALU operands
//  ADDR_W  10  RAM address width (1024 words per port)
//  OP_W    3   ALU op-code width
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high; clears all state
//  start       in   1       one-cycle pulse; accepted only in IDLE
//  op          in   OP_W    ALU op, latched at start
//  base_a      in   ADDR_W  start address of operand A, latched at start
//  base_b      in   ADDR_W  start address of operand B, latched at start
//  base_c      in   ADDR_W  start address of result, latched at start
//  len         in   ADDR_W  element count (rows*cols); 0 allowed
//  busy        out  1       high from accepted start until DONE exits
//  done        out  1       one-cycle pulse when sequence completes
//  addr_a      out  ADDR_W  RAM port A address
//  data_a      out  DATA_W  RAM port A write data
//  we_a        out  1       RAM port A write enable
//  q_a         in   DATA_W  RAM port A read data (1-cycle latency)
//  addr_b      out  ADDR_W  RAM port B address
//  we_b        out  1       RAM port B write enable, tied 0 (read-only use)
//  q_b         in   DATA_W  RAM port B read data (1-cycle latency)
//  alu_op      out  OP_W    op to ALU (latched op)
//  alu_x/alu_y out  DATA_W  ALU operands (registered q_a / q_b)
//  alu_res     in   DATA_W  ALU result, combinational from alu_x/alu_y/alu_op
// BEHAVIOUR
//  Reset values: busy=0, done=0, we_a=0, we_b=0, addr_a=0, addr_b=0, data_a=0,
//   alu_x=0, alu_y=0, alu_op=0; state=IDLE; index=0.
//  FSM: IDLE -> READ -> WAIT -> EXEC -> WRITE -> (READ | DONE); DONE -> IDLE.
//  IDLE:  on start, latch op/bases/len, index<=0, busy<=1.
//         If len==0, go to DONE; otherwise go to READ.
//  READ:  addr_a=base_a+index, addr_b=base_b+index.
//  WAIT:  RAM latency cycle; q_a/q_b valid at end.
//  EXEC:  alu_x<=q_a, alu_y<=q_b.
//  WRITE: addr_a=base_c+index, data_a=alu_res, we_a=1 (this cycle only).
//         index<=index+1; go to DONE when index==len-1, else go to READ.
//  DONE:  done=1 for one cycle, busy<=0, go to IDLE.
//  Throughput: 4 cycles per element; total 4*len+2 cycles from start to done.
//  Address arithmetic is modulo 2^ADDR_W: base+index wraps silently (1023+1 -> 0).
//  In-place operation (base_c==base_a or base_b) is legal: element i is read
//   before it is written.
//  start while busy is ignored; a start coincident with DONE is ignored.
//  Async reset mid-sequence: we_a drops immediately; partial results remain in RAM.
// CONFIGURATION
//  MSEQ_ABORT_EN defined:
//   - adds input abort (1 bit).
//   - abort high in any non-IDLE state forces DONE next cycle; a WRITE in that
//     same cycle still completes.
//   - adds output aborted (1 bit), set alongside done and cleared at next start.
//  MSEQ_ABORT_EN undefined: neither port exists; the sequence always runs to len.
// STRUCTURE
//  mseq_defs.vh: state encodings (S_IDLE..S_DONE, 3-bit) and ALU op-code localparams.
//  Sub-module mseq_index_counter: clear/inc of index, plus last = (index==len-1).
//  The FSM and address muxing stay in the top.
// TESTING
//  1. Reset: assert reset mid-WRITE -> we_a=0 same cycle, busy=0, state IDLE.
//  2. op=ADD, base_a=0, base_b=16, base_c=32, len=4, A={1,2,3,4}, B={10,20,30,40}
//     -> RAM[32..35]={11,22,33,44}; done at cycle 18 after start.
//  3. len=0 -> done two cycles after start, no we_a pulse.
//  4. base_a=1022, base_b=0, base_c=1022, len=3 -> A addresses 1022,1023,0 (wrap).
//     In-place results are correct.
//  5. Second start while busy -> ignored; a single done pulse; bases unchanged.
//  6. MSEQ_ABORT_EN: abort during element 2 of len=8 -> done and aborted next cycle.
//     Only elements 0..1 (or 0..2 if abort lands in WRITE) are written.

Source files
------------

// File: rtl/matrix_op_sequencer_pkg.sv
// Shared definitions for the matrix op sequencer: FSM state encoding and the
// op codes understood by the external matrix ALU.
package matrix_op_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_EXEC  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } mseq_state_e;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_MUL  = 3'd5;
   localparam logic [2:0] OP_PASA = 3'd6;
   localparam logic [2:0] OP_PASB = 3'd7;

endpackage

// File: rtl/matrix_op_sequencer_index_counter.sv
// Element index for the sequencer: cleared on an accepted start, bumped once
// per WRITE; last flags the final element of the latched length.
module matrix_op_sequencer_index_counter
   import matrix_op_sequencer_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              inc,
   input  logic [ADDR_W-1:0] len,
   output logic [ADDR_W-1:0] index,
   output logic              last
);

   logic [ADDR_W-1:0] index_q;
   logic [ADDR_W-1:0] index_d;

   // next index: clear wins over increment
   always_comb begin
      index_d = index_q;
      if (clear) begin
         index_d = {ADDR_W{1'b0}};
      end else if (inc) begin
         index_d = index_q + ADDR_W'(1);
      end else begin
         index_d = index_q;
      end
   end

   // index register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index_q <= {ADDR_W{1'b0}};
      end else begin
         index_q <= index_d;
      end
   end

   assign index = index_q;
   assign last  = (index_q == (len - ADDR_W'(1)));

endmodule

// File: rtl/matrix_op_sequencer.sv
// Element-by-element sequencer between the start/done FSM, the dual-port matrix
// RAM and the combinational ALU. Optional abort: define MSEQ_ABORT_EN.
module matrix_op_sequencer
   import matrix_op_sequencer_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int OP_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OP_W-1:0]   op,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   input  logic [ADDR_W-1:0] base_c,
   input  logic [ADDR_W-1:0] len,
`ifdef MSEQ_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] addr_a,
   output logic [DATA_W-1:0] data_a,
   output logic              we_a,
   input  logic [DATA_W-1:0] q_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic              we_b,
   input  logic [DATA_W-1:0] q_b,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_x,
   output logic [DATA_W-1:0] alu_y,
   input  logic [DATA_W-1:0] alu_res
);

   mseq_state_e state_q, state_d, state_nrm;
   logic [OP_W-1:0]   op_q, op_d;
   logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic [DATA_W-1:0] data_a_q, data_a_d, alu_x_q, alu_x_d, alu_y_q, alu_y_d;
   logic              we_a_q, we_a_d, busy_q, busy_d, done_q, done_d;
   logic              ctr_clear, ctr_inc, last, abort_hit;
   logic [ADDR_W-1:0] index;

   matrix_op_sequencer_index_counter #(.ADDR_W(ADDR_W)) u_index (
      .clk   (clk),
      .reset (reset),
      .clear (ctr_clear),
      .inc   (ctr_inc),
      .len   (len_q),
      .index (index),
      .last  (last)
   );

`ifdef MSEQ_ABORT_EN
   logic aborted_q, aborted_d;

   assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE);

   // aborted flag: raised with the forced DONE, cleared by the next accepted start
   always_comb begin
      if ((state_q == S_IDLE) && start) begin
         aborted_d = 1'b0;
      end else if (abort_hit) begin
         aborted_d = 1'b1;
      end else begin
         aborted_d = aborted_q;
      end
   end

   // aborted flag register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aborted_q <= 1'b0;
      end else begin
         aborted_q <= aborted_d;
      end
   end

   assign aborted = aborted_q;
`else
   assign abort_hit = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; an abort overrides the normal walk
   always_comb begin
      state_nrm = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_nrm = (len == {ADDR_W{1'b0}}) ? S_DONE : S_READ;
            end else begin
               state_nrm = S_IDLE;
            end
         end
         S_READ:  state_nrm = S_WAIT;
         S_WAIT:  state_nrm = S_EXEC;
         S_EXEC:  state_nrm = S_WRITE;
         S_WRITE: state_nrm = last ? S_DONE : S_READ;
         S_DONE:  state_nrm = S_IDLE;
         default: state_nrm = S_IDLE;
      endcase
      state_d = abort_hit ? S_DONE : state_nrm;
   end

   // output/datapath next values; strobes are decoded from the state being entered
   // so every RAM and handshake output comes straight from a flop
   always_comb begin
      op_d      = op_q;
      base_a_d  = base_a_q;
      base_b_d  = base_b_q;
      base_c_d  = base_c_q;
      len_d     = len_q;
      addr_a_d  = addr_a_q;
      addr_b_d  = addr_b_q;
      data_a_d  = data_a_q;
      alu_x_d   = alu_x_q;
      alu_y_d   = alu_y_q;
      ctr_clear = 1'b0;
      ctr_inc   = 1'b0;
      we_a_d    = (state_d == S_WRITE);
      done_d    = (state_d == S_DONE);
      busy_d    = (state_d != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d      = op;
               base_a_d  = base_a;
               base_b_d  = base_b;
               base_c_d  = base_c;
               len_d     = len;
               addr_a_d  = base_a;
               addr_b_d  = base_b;
               ctr_clear = 1'b1;
            end else begin
               ctr_clear = 1'b0;
            end
         end
         S_WAIT: begin
            alu_x_d = q_a;
            alu_y_d = q_b;
         end
         S_EXEC: begin
            addr_a_d = base_c_q + index;
            data_a_d = alu_res;
         end
         S_WRITE: begin
            ctr_inc  = 1'b1;
            addr_a_d = base_a_q + index + ADDR_W'(1);
            addr_b_d = base_b_q + index + ADDR_W'(1);
         end
         default: begin
            ctr_inc = 1'b0;
         end
      endcase
   end

   // latched command and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= {OP_W{1'b0}};
         base_a_q <= {ADDR_W{1'b0}};
         base_b_q <= {ADDR_W{1'b0}};
         base_c_q <= {ADDR_W{1'b0}};
         len_q    <= {ADDR_W{1'b0}};
         addr_a_q <= {ADDR_W{1'b0}};
         addr_b_q <= {ADDR_W{1'b0}};
         data_a_q <= {DATA_W{1'b0}};
         alu_x_q  <= {DATA_W{1'b0}};
         alu_y_q  <= {DATA_W{1'b0}};
         we_a_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         op_q     <= op_d;
         base_a_q <= base_a_d;
         base_b_q <= base_b_d;
         base_c_q <= base_c_d;
         len_q    <= len_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         data_a_q <= data_a_d;
         alu_x_q  <= alu_x_d;
         alu_y_q  <= alu_y_d;
         we_a_q   <= we_a_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign addr_a = addr_a_q;
   assign data_a = data_a_q;
   assign we_a   = we_a_q;
   assign addr_b = addr_b_q;
   assign we_b   = 1'b0;
   assign alu_op = op_q;
   assign alu_x  = alu_x_q;
   assign alu_y  = alu_y_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Bench for matrix_op_sequencer: behavioural RAM and ALU around the DUT, and a
// whole-memory reference model computed element by element from the op rules.
module tb_matrix_op_sequencer;
   import matrix_op_sequencer_pkg::*;

   localparam int DW = 16;
   localparam int AW = 10;
   localparam int OW = 3;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [OW-1:0] op;
   logic [AW-1:0] base_a, base_b, base_c, len;
   logic          busy, done, we_a, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] data_a, q_a, q_b, alu_x, alu_y, alu_res;
   logic [OW-1:0] alu_op;
`ifdef MSEQ_ABORT_EN
   logic          abort, aborted;
`endif

   logic [DW-1:0] mem      [DEPTH];
   logic [DW-1:0] init_mem [DEPTH];
   logic [DW-1:0] exp_mem  [DEPTH];
   logic          load;
   int            addr_log [256];
   logic          we_log   [256];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   matrix_op_sequencer dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .base_a  (base_a),
      .base_b  (base_b),
      .base_c  (base_c),
      .len     (len),
`ifdef MSEQ_ABORT_EN
      .abort   (abort),
      .aborted (aborted),
`endif
      .busy    (busy),
      .done    (done),
      .addr_a  (addr_a),
      .data_a  (data_a),
      .we_a    (we_a),
      .q_a     (q_a),
      .addr_b  (addr_b),
      .we_b    (we_b),
      .q_b     (q_b),
      .alu_op  (alu_op),
      .alu_x   (alu_x),
      .alu_y   (alu_y),
      .alu_res (alu_res)
   );

   function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
      logic [2*DW-1:0] p;
      p = x * y;
      case (o)
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         OP_XOR:  return x ^ y;
         OP_MUL:  return p[DW-1:0];
         OP_PASA: return x;
         default: return y;
      endcase
   endfunction

   assign alu_res = alu_f(alu_op, alu_x, alu_y);

   // dual-port RAM, synchronous read with one cycle latency; preload port for the bench
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
      end else begin
         if (we_a) mem[addr_a] <= data_a;
         if (we_b) mem[addr_b] <= 16'hdead;
         q_a <= mem[addr_a];
         q_b <= mem[addr_b];
      end
   end

   task automatic load_random();
      for (int i = 0; i < DEPTH; i++) init_mem[i] = DW'($urandom);
      @(negedge clk); load = 1'b1;
      @(negedge clk); load = 1'b0;
   endtask

   task automatic load_init();
      @(negedge clk); load = 1'b1;
      @(negedge clk); load = 1'b0;
   endtask

   // reference: the first n elements applied in order on a snapshot of the RAM
   task automatic build_expected(input logic [OW-1:0] o, input int ba, input int bb, input int bc, input int n);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = mem[i];
      for (int i = 0; i < n; i++) begin
         exp_mem[(bc + i) % DEPTH] = alu_f(o, exp_mem[(ba + i) % DEPTH], exp_mem[(bb + i) % DEPTH]);
      end
   endtask

   function automatic int mem_diffs();
      int d = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) d++;
      return d;
   endfunction

   // drives one sequence; lat is the cycle count (start edge = 1 edge) at which done is first seen
   task automatic run_seq(input logic [OW-1:0] o, input int ba, input int bb, input int bc, input int n,
                          input int dup_cyc, input int edge_cyc, input int abort_cyc,
                          output int lat, output int writes, output int dones, output logic busy_after,
                          output logic abt);
      int budget;
      budget = 4 * n + 20;
      lat = -1; writes = 0; dones = 0; abt = 1'b0;
      @(negedge clk);
      op = o; base_a = AW'(ba); base_b = AW'(bb); base_c = AW'(bc); len = AW'(n); start = 1'b1;
      for (int c = 1; c <= budget && c < 256; c++) begin
         @(negedge clk);
         start = 1'b0;
`ifdef MSEQ_ABORT_EN
         abort = 1'b0;
         if (done && lat < 0) abt = aborted;
         if (c == abort_cyc) abort = 1'b1;
`endif
         addr_log[c] = int'(addr_a);
         we_log[c] = we_a;
         if (we_a) writes++;
         if (done) begin
            dones++;
            if (lat < 0) lat = c;
         end
         if (c == dup_cyc) begin
            start = 1'b1; base_a = ~base_a; base_b = ~base_b; base_c = ~base_c; len = ~len;
         end
         if (c == edge_cyc) start = 1'b1;
         if (lat >= 0 && c == lat + 3) break;
      end
      start = 1'b0;
      busy_after = busy;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, we_a, we_b, addr_a, addr_b, data_a, alu_x, alu_y, alu_op} !== '0)
         begin errors++; $display("FAIL reset_outputs: got busy=%b done=%b we_a=%b addr_a=%0d data_a=%h alu_x=%h alu_op=%0d expected all 0", busy, done, we_a, addr_a, data_a, alu_x, alu_op); end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_add();
      int lat, wr, dn; logic ba, ab;
      for (int i = 0; i < DEPTH; i++) init_mem[i] = DW'($urandom);
      for (int i = 0; i < 4; i++) begin
         init_mem[i] = DW'(i + 1);
         init_mem[16 + i] = DW'(10 * (i + 1));
      end
      load_init();
      build_expected(OP_ADD, 0, 16, 32, 4);
      run_seq(OP_ADD, 0, 16, 32, 4, -1, -1, -1, lat, wr, dn, ba, ab);
      checks++;
      if ({mem[32], mem[33], mem[34], mem[35]} !== {16'd11, 16'd22, 16'd33, 16'd44})
         begin errors++; $display("FAIL add_results: got %0d %0d %0d %0d expected 11 22 33 44", mem[32], mem[33], mem[34], mem[35]); end
      checks++;
      if (lat !== 17) begin errors++; $display("FAIL add_latency: got %0d expected 17 (cycle 18 counting start)", lat); end
      checks++;
      if (wr !== 4 || dn !== 1) begin errors++; $display("FAIL add_pulses: got writes=%0d dones=%0d expected 4 1", wr, dn); end
      checks++;
      if (mem_diffs() !== 0) begin errors++; $display("FAIL add_memory: got %0d differing words expected 0", mem_diffs()); end
   endtask

   task automatic test_len_zero();
      int lat, wr, dn; logic ba, ab;
      load_random();
      build_expected(OP_XOR, 5, 6, 7, 0);
      run_seq(OP_XOR, 5, 6, 7, 0, -1, -1, -1, lat, wr, dn, ba, ab);
      checks++;
      if (lat !== 1 || wr !== 0 || dn !== 1)
         begin errors++; $display("FAIL len_zero: got lat=%0d writes=%0d dones=%0d expected 1 0 1", lat, wr, dn); end
      checks++;
      if (ba !== 1'b0 || mem_diffs() !== 0) begin errors++; $display("FAIL len_zero_state: got busy=%b diffs=%0d expected 0 0", ba, mem_diffs()); end
   endtask

   task automatic test_wrap();
      int lat, wr, dn; logic ba, ab;
      load_random();
      build_expected(OP_SUB, 1022, 0, 1022, 3);
      run_seq(OP_SUB, 1022, 0, 1022, 3, -1, -1, -1, lat, wr, dn, ba, ab);
      checks++;
      if (addr_log[1] !== 1022 || addr_log[5] !== 1023 || addr_log[9] !== 0)
         begin errors++; $display("FAIL wrap_read_addr: got %0d %0d %0d expected 1022 1023 0", addr_log[1], addr_log[5], addr_log[9]); end
      checks++;
      if (!(we_log[4] && we_log[8] && we_log[12]) || addr_log[4] !== 1022 || addr_log[8] !== 1023 || addr_log[12] !== 0)
         begin errors++; $display("FAIL wrap_write_addr: got %0d %0d %0d expected 1022 1023 0 with we_a", addr_log[4], addr_log[8], addr_log[12]); end
      checks++;
      if (mem_diffs() !== 0 || lat !== 13) begin errors++; $display("FAIL wrap_inplace: got diffs=%0d lat=%0d expected 0 13", mem_diffs(), lat); end
   endtask

   task automatic test_busy_start();
      int lat, wr, dn; logic ba, ab;
      load_random();
      build_expected(OP_MUL, 40, 300, 700, 5);
      run_seq(OP_MUL, 40, 300, 700, 5, 6, 21, -1, lat, wr, dn, ba, ab);
      checks++;
      if (dn !== 1 || lat !== 21) begin errors++; $display("FAIL busy_start_done: got dones=%0d lat=%0d expected 1 21", dn, lat); end
      checks++;
      if (ba !== 1'b0) begin errors++; $display("FAIL start_at_done: got busy=%b expected 0", ba); end
      checks++;
      if (mem_diffs() !== 0 || wr !== 5) begin errors++; $display("FAIL busy_start_mem: got diffs=%0d writes=%0d expected 0 5", mem_diffs(), wr); end
   endtask

   task automatic test_random();
      int lat, wr, dn, ba_i, bb_i, bc_i, n; logic ba, ab; logic [OW-1:0] o;
      for (int it = 0; it < 8; it++) begin
         load_random();
         o = OW'($urandom_range(0, 7));
         ba_i = $urandom_range(0, 1023); bb_i = $urandom_range(0, 1023); bc_i = $urandom_range(0, 1023);
         n = $urandom_range(0, 12);
         build_expected(o, ba_i, bb_i, bc_i, n);
         run_seq(o, ba_i, bb_i, bc_i, n, -1, -1, -1, lat, wr, dn, ba, ab);
         checks++;
         if (lat !== 4 * n + 1 || wr !== n || dn !== 1)
            begin errors++; $display("FAIL random_timing: it=%0d n=%0d got lat=%0d writes=%0d dones=%0d expected %0d %0d 1", it, n, lat, wr, dn, 4 * n + 1, n); end
         checks++;
         if (mem_diffs() !== 0)
            begin errors++; $display("FAIL random_mem: it=%0d op=%0d a=%0d b=%0d c=%0d n=%0d got %0d differing words expected 0", it, o, ba_i, bb_i, bc_i, n, mem_diffs()); end
      end
   endtask

   task automatic test_reset_mid_write();
      int nw, lat, wr, dn; logic hit, ba, ab;
      load_random();
      build_expected(OP_ADD, 100, 200, 300, 1);
      @(negedge clk);
      op = OP_ADD; base_a = 10'd100; base_b = 10'd200; base_c = 10'd300; len = 10'd4; start = 1'b1;
      nw = 0; hit = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (we_a) nw++;
         if (nw == 2) begin hit = 1'b1; break; end
      end
      checks++;
      if (hit !== 1'b1) begin errors++; $display("FAIL reset_find_write: got %0d writes expected 2", nw); end
      reset = 1'b1;
      #1;
      checks++;
      if ({we_a, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_mid_write: got we_a=%b busy=%b done=%b expected 0 0 0", we_a, busy, done); end
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (mem_diffs() !== 0) begin errors++; $display("FAIL reset_partial: got %0d differing words expected 0", mem_diffs()); end
      run_seq(OP_ADD, 0, 0, 0, 0, -1, -1, -1, lat, wr, dn, ba, ab);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL reset_to_idle: got lat=%0d expected 1", lat); end
   endtask

`ifdef MSEQ_ABORT_EN
   task automatic test_abort();
      int lat, wr, dn; logic ba, ab;
      load_random();
      build_expected(OP_ADD, 0, 100, 200, 2);
      run_seq(OP_ADD, 0, 100, 200, 8, -1, -1, 9, lat, wr, dn, ba, ab);
      checks++;
      if (lat !== 10 || ab !== 1'b1 || wr !== 2 || mem_diffs() !== 0)
         begin errors++; $display("FAIL abort_read: got lat=%0d aborted=%b writes=%0d diffs=%0d expected 10 1 2 0", lat, ab, wr, mem_diffs()); end
      load_random();
      build_expected(OP_SUB, 0, 100, 200, 3);
      run_seq(OP_SUB, 0, 100, 200, 8, -1, -1, 12, lat, wr, dn, ba, ab);
      checks++;
      if (lat !== 13 || ab !== 1'b1 || wr !== 3 || mem_diffs() !== 0)
         begin errors++; $display("FAIL abort_write: got lat=%0d aborted=%b writes=%0d diffs=%0d expected 13 1 3 0", lat, ab, wr, mem_diffs()); end
      run_seq(OP_OR, 3, 4, 5, 1, -1, -1, -1, lat, wr, dn, ba, ab);
      checks++;
      if (ab !== 1'b0 || lat !== 5) begin errors++; $display("FAIL abort_clear: got aborted=%b lat=%0d expected 0 5", ab, lat); end
   endtask
`endif

   initial begin
      start = 1'b0; load = 1'b0; op = '0; base_a = '0; base_b = '0; base_c = '0; len = '0;
`ifdef MSEQ_ABORT_EN
      abort = 1'b0;
`endif
      test_reset();
      test_add();
      test_len_zero();
      test_wrap();
      test_busy_start();
      test_random();
      test_reset_mid_write();
`ifdef MSEQ_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
